// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer for a 1-bit ALU slice: feeds operand bits LSB first,
// chains carry-out into carry-in and assembles the WIDTH-bit result and flags.
module serial_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             bnegate,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_bnegate,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    input  logic             alu_result,
    input  logic             alu_cout
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [2:0] OP_ADD = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_l, b_l, result_sr, final_val;
    logic [2:0]       op_l;
    logic             bnegate_l, cin_reg, is_arith, last_bit;
    logic [IW-1:0]    idx;

    assign is_arith  = (op_l == OP_ADD);
    assign last_bit  = (idx == LAST_IDX);
    // The bit arriving on this edge completes the value; flags use it directly.
    assign final_val = {alu_result, result_sr[WIDTH-1:1]};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_a       = 1'b0;
        alu_b       = 1'b0;
        alu_bnegate = 1'b0;
        alu_op      = 3'b000;
        alu_cin     = 1'b0;
        if (state == RUN) begin
            alu_a       = a_l[idx];
            alu_b       = b_l[idx];
            alu_bnegate = bnegate_l;
            alu_op      = op_l;
            alu_cin     = cin_reg;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_l       <= '0;
            b_l       <= '0;
            op_l      <= 3'b000;
            bnegate_l <= 1'b0;
            idx       <= '0;
            cin_reg   <= 1'b0;
            result_sr <= '0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_l       <= a;
                        b_l       <= b;
                        op_l      <= op;
                        bnegate_l <= bnegate;
                        idx       <= '0;
                        cin_reg   <= (op == OP_ADD) & bnegate;
                        result_sr <= '0;
                    end
                end
                RUN: begin
                    result_sr <= final_val;
                    cin_reg   <= alu_cout;
                    idx       <= idx + IW'(1);
                    if (last_bit) begin
                        result   <= final_val;
                        zero     <= (final_val == '0);
                        carry    <= is_arith & alu_cout;
                        // cin_reg holds the carry into the MSB at this point.
                        overflow <= is_arith & (cin_reg ^ alu_cout);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
Bit-serial sequencer placed directly upstream of the 1-bit ALU slice (ALU1Bit), so the CPU datapath can run 16-bit AND/OR/XOR/ADD/SUB on a single slice. On each start it latches the operands and presents one bit pair per cycle, LSB first. It chains the slice's carry-out back into carry-in and assembles the WIDTH-bit result plus flags. Sits between the decode/operand-read stage and the writeback register.

Parameters:
WIDTH, 16, operand/result width in bits (≥2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request new operation; sampled only in IDLE
op  input  3  000 AND, 010 OR, 011 XOR, 100 ADD (other codes passed through to slice, no arithmetic flags)
bnegate  input  1  with op=100: subtract (A-B)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, result/flags valid
result  output  WIDTH  assembled result, held until next start
carry  output  1  final carry-out (ADD/SUB only, else 0)
zero  output  1  result == 0
overflow  output  1  signed overflow (ADD/SUB only, else 0)
alu_a  output  1  bit of A to slice
alu_b  output  1  bit of B to slice
alu_bnegate  output  1  to slice Bnegate
alu_op  output  3  to slice operation
alu_cin  output  1  to slice CIN
alu_result  input  1  slice Result
alu_cout  input  1  slice cout

Behaviour:
- Reset (async, rst_n=0): state IDLE; bit index, result, carry, zero, overflow, busy, done, all alu_* outputs = 0. Reset mid-operation abandons the op; no done pulse.
- States: IDLE -> RUN on start; RUN -> DONE after bit WIDTH-1 is captured; DONE -> IDLE unconditionally after one cycle.
- IDLE + start at edge E0: latch a, b, op, bnegate; idx <= 0; cin_reg <= (op==100) & bnegate; clear result shift register.
- RUN, combinational drive: alu_a=a_l[idx], alu_b=b_l[idx], alu_op=op_l, alu_bnegate=bnegate_l, alu_cin=cin_reg. Outside RUN all alu_* outputs = 0.
- RUN, each edge: result_sr <= {alu_result, result_sr[WIDTH-1:1]}; cin_reg <= alu_cout; idx <= idx+1.
- At the edge capturing idx=WIDTH-1: carry <= alu_cout (ADD/SUB); overflow <= cin_reg ^ alu_cout (cin_reg at that point is the carry into MSB); zero computed from the final assembled value; state -> DONE.
- Latency: start at E0, bits captured at E1..E(WIDTH), done high in the cycle after E(WIDTH), i.e. WIDTH+1 cycles from start. Back-to-back: a start in the cycle after DONE is accepted (earliest every WIDTH+2 cycles).
- start while busy: ignored; a/b/op changes while busy have no effect.
- result/carry/zero/overflow are updated only at completion. They hold their values through IDLE until the next completion. The shift register is internal, so partial values never appear on result.
- Non-ADD ops: carry=overflow=0. cin_reg still follows alu_cout but does not affect the logical ops.
- SUB convention: carry=1 means no borrow.

Test Plan:
- ADD a=0x1234 b=0x0FF1 -> done at cycle 17 after start, result=0x2225, carry=0, zero=0, overflow=0.
- SUB a=0x0005 b=0x0007 -> result=0xFFFE, carry=0, overflow=0. SUB a=0x8000 b=0x0001 -> result=0x7FFF, carry=1, overflow=1.
- ADD a=0x7FFF b=0x0001 -> result=0x8000, overflow=1, carry=0. ADD 0xFFFF+0x0001 -> result=0x0000, carry=1, zero=1.
- AND 0xF0F0&0x0FF0 -> 0x00F0. OR -> 0xFFF0. XOR 0xAAAA^0xAAAA -> 0x0000, zero=1; carry=overflow=0 for all three.
- start pulsed again at cycle 5 of an ADD with different operands -> ignored, first result unchanged; busy high for exactly 17 cycles.
- rst_n low at cycle 8 of an op -> immediately IDLE, all outputs 0, no done pulse. A new op after release completes correctly.
